// File: rtl/conv_ctrl_pkg.sv
// rtl/conv_ctrl_pkg.sv - state encoding and datapath select codes for the convolution controller
package conv_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        LOAD_FILTER,
        INIT_LOAD,
        INIT_SHIFT,
        WINDOW_LOAD,
        CALC,
        STORE_RES_BUF,
        STORE_TO_MEM,
        SHIFT_UPDATE,
        BUF_LOAD_UPDATE,
        FLUSH,
        DONE
    } state_e;

    localparam logic [1:0] OFS_FILTER = 2'b00;
    localparam logic [1:0] OFS_WRITE  = 2'b01;
    localparam logic [1:0] OFS_LINE   = 2'b10;

    localparam logic [1:0] BASE_X = 2'b00;
    localparam logic [1:0] BASE_Y = 2'b01;
    localparam logic [1:0] BASE_Z = 2'b10;

endpackage

// File: rtl/ctrl_sat_counter.sv
// rtl/ctrl_sat_counter.sv - saturating up-counter with synchronous clear and terminal-value compare
module ctrl_sat_counter #(
    parameter int W    = 5,
    parameter int TERM = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_value,
    output logic         o_at_term
);

    localparam logic [W-1:0] MAX_V  = '1;
    localparam logic [W-1:0] TERM_V = TERM[W-1:0];

    logic [W-1:0] r_value;

    // Clear wins over increment; the count holds at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_inc && (r_value != MAX_V)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign o_value   = r_value;
    assign o_at_term = (r_value == TERM_V);

endmodule

// File: rtl/conv_controller_param.sv
// rtl/conv_controller_param.sv - parametrised sequencer for filter load, line fill, window MAC and write-back
module conv_controller_param
    import conv_ctrl_pkg::*;
#(
    parameter int FILTER_ROWS = 4,
    parameter int IMG_ROWS    = 16,
    parameter int STRIDE      = 1,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       offsetDone,
    input  logic       mbcZero,
    input  logic       raDone,
    input  logic       rbFull,
    input  logic       rbEmpty,
    output logic       offsetActive,
    output logic       offsetRst,
    output logic       memREn,
    output logic       memWEn,
    output logic       fblRst,
    output logic       fblAct,
    output logic       filBufRst,
    output logic       filBufLd,
    output logic       fillBufISel,
    output logic       mbRst,
    output logic       mbShift,
    output logic       mbWrite,
    output logic       mblRst,
    output logic       mblAct,
    output logic       mbcRst,
    output logic       mbcEn,
    output logic       macClear,
    output logic       rbClear,
    output logic       wbRst,
    output logic       wbLd,
    output logic       raAct,
    output logic       macRst,
    output logic       macAct,
    output logic       rbRst,
    output logic       rbEn,
    output logic [1:0] offsetMode,
    output logic [1:0] baseAddrSel,
    output logic       busy,
    output logic       done
);

    localparam int INIT_TERM = FILTER_ROWS - 1;
    localparam int UPD_TERM  = (IMG_ROWS - FILTER_ROWS) / STRIDE;
    localparam int SH_TERM   = STRIDE - 1;

    state_e r_state;

    logic               w_cnt_clr;
    logic               w_init_inc;
    logic               w_upd_inc;
    logic               w_sh_clr;
    logic               w_sh_inc;
    logic               w_init_term;
    logic               w_upd_term;
    logic               w_sh_term;
    logic [CNT_W-1:0]   w_unused_init_val;
    logic [CNT_W-1:0]   w_unused_upd_val;
    logic [CNT_W-1:0]   w_unused_sh_val;
    state_e             w_row_end;

    assign w_cnt_clr  = (r_state == CLEAR);
    assign w_init_inc = (r_state == INIT_LOAD) && offsetDone && !w_init_term;
    assign w_upd_inc  = (r_state == BUF_LOAD_UPDATE) && offsetDone && w_sh_term;
    assign w_sh_clr   = w_cnt_clr || w_upd_inc;
    assign w_sh_inc   = (r_state == BUF_LOAD_UPDATE) && offsetDone && !w_sh_term;

    ctrl_sat_counter #(.W(CNT_W), .TERM(INIT_TERM)) u_init_cnt (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_cnt_clr),
        .i_inc     (w_init_inc),
        .o_value   (w_unused_init_val),
        .o_at_term (w_init_term)
    );

    ctrl_sat_counter #(.W(CNT_W), .TERM(UPD_TERM)) u_upd_cnt (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_cnt_clr),
        .i_inc     (w_upd_inc),
        .o_value   (w_unused_upd_val),
        .o_at_term (w_upd_term)
    );

    ctrl_sat_counter #(.W(CNT_W), .TERM(SH_TERM)) u_sh_cnt (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_sh_clr),
        .i_inc     (w_sh_inc),
        .o_value   (w_unused_sh_val),
        .o_at_term (w_sh_term)
    );

    // End-of-window decision shared by both store states; never a state of its own.
    assign w_row_end = !mbcZero   ? WINDOW_LOAD :
                       w_upd_term ? FLUSH       : SHIFT_UPDATE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:            if (start) r_state <= CLEAR;
                CLEAR:           r_state <= LOAD_FILTER;
                LOAD_FILTER:     if (offsetDone) r_state <= INIT_LOAD;
                INIT_LOAD:       if (offsetDone) r_state <= w_init_term ? WINDOW_LOAD : INIT_SHIFT;
                INIT_SHIFT:      r_state <= INIT_LOAD;
                WINDOW_LOAD:     r_state <= CALC;
                CALC:            if (raDone) r_state <= STORE_RES_BUF;
                STORE_RES_BUF:   r_state <= rbFull ? STORE_TO_MEM : w_row_end;
                STORE_TO_MEM:    r_state <= w_row_end;
                SHIFT_UPDATE:    r_state <= BUF_LOAD_UPDATE;
                BUF_LOAD_UPDATE: if (offsetDone) r_state <= w_sh_term ? WINDOW_LOAD : SHIFT_UPDATE;
                FLUSH:           r_state <= DONE;
                DONE:            if (!start) r_state <= IDLE;
                default:         r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        offsetActive = 1'b0;
        offsetRst    = 1'b0;
        memREn       = 1'b0;
        memWEn       = 1'b0;
        fblRst       = 1'b0;
        fblAct       = 1'b0;
        filBufRst    = 1'b0;
        filBufLd     = 1'b0;
        fillBufISel  = 1'b0;
        mbRst        = 1'b0;
        mbShift      = 1'b0;
        mbWrite      = 1'b0;
        mblRst       = 1'b0;
        mblAct       = 1'b0;
        mbcRst       = 1'b0;
        mbcEn        = 1'b0;
        macClear     = 1'b0;
        rbClear      = 1'b0;
        wbRst        = 1'b0;
        wbLd         = 1'b0;
        raAct        = 1'b0;
        macRst       = 1'b0;
        macAct       = 1'b0;
        rbRst        = 1'b0;
        rbEn         = 1'b0;
        offsetMode   = OFS_FILTER;
        baseAddrSel  = BASE_X;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            CLEAR: begin
                busy      = 1'b1;
                offsetRst = 1'b1;
                fblRst    = 1'b1;
                filBufRst = 1'b1;
                mbRst     = 1'b1;
                mbcRst    = 1'b1;
                mblRst    = 1'b1;
                wbRst     = 1'b1;
                macRst    = 1'b1;
                rbRst     = 1'b1;
            end
            LOAD_FILTER: begin
                busy         = 1'b1;
                offsetActive = 1'b1;
                offsetMode   = OFS_FILTER;
                baseAddrSel  = BASE_Y;
                memREn       = 1'b1;
                fblAct       = 1'b1;
                filBufLd     = 1'b1;
                fillBufISel  = 1'b1;
            end
            INIT_LOAD, BUF_LOAD_UPDATE: begin
                busy         = 1'b1;
                offsetActive = 1'b1;
                offsetMode   = OFS_LINE;
                baseAddrSel  = BASE_X;
                memREn       = 1'b1;
                mbWrite      = 1'b1;
                mblAct       = 1'b1;
            end
            INIT_SHIFT, SHIFT_UPDATE: begin
                busy    = 1'b1;
                mbShift = 1'b1;
            end
            WINDOW_LOAD: begin
                busy  = 1'b1;
                wbLd  = 1'b1;
                mbcEn = 1'b1;
            end
            CALC: begin
                busy   = 1'b1;
                raAct  = 1'b1;
                macAct = 1'b1;
            end
            STORE_RES_BUF: begin
                busy     = 1'b1;
                rbEn     = 1'b1;
                macClear = 1'b1;
            end
            STORE_TO_MEM, FLUSH: begin
                busy = 1'b1;
                // An empty result buffer makes FLUSH a silent pass-through to DONE.
                if ((r_state == STORE_TO_MEM) || !rbEmpty) begin
                    offsetActive = 1'b1;
                    offsetMode   = OFS_WRITE;
                    baseAddrSel  = BASE_Z;
                    memWEn       = 1'b1;
                    rbClear      = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
